// File: rtl/flopoco_pkg.sv
// flopoco_pkg: shared widths, exception codes and result classes for FloPoCo-to-IEEE conversion
package flopoco_pkg;
  localparam int WE = 8;
  localparam int WF = 23;
  localparam int FLOPOCO_W = 34;
  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF = 2'b10;
  localparam logic [1:0] EXN_NAN = 2'b11;
  localparam logic [31:0] IEEE_QNAN = 32'h7FC00000;
  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_FLUSH, CLS_OVF, CLS_INF, CLS_NAN} cls_t;
endpackage

// File: rtl/flopoco_classify.sv
// flopoco_classify: combinational map of a FloPoCo word to its result class and IEEE single word
module flopoco_classify
  import flopoco_pkg::*;
(
  input  logic [FLOPOCO_W-1:0] word,
  output cls_t                 cls,
  output logic [31:0]          ieee
);
  logic [1:0] exn;
  logic sgn;
  logic [WE-1:0] e;
  logic [WF-1:0] f;
  assign {exn, sgn, e, f} = word;
  always_comb begin
    cls = exn == EXN_ZERO ? CLS_ZERO :
          exn == EXN_INF  ? CLS_INF  :
          exn == EXN_NAN  ? CLS_NAN  :
          e == '0         ? CLS_FLUSH :
          &e              ? CLS_OVF  : CLS_NORM;
    ieee = cls == CLS_NAN  ? IEEE_QNAN :
           cls == CLS_NORM ? {sgn, e, f} :
           (cls == CLS_INF || cls == CLS_OVF) ? {sgn, {WE{1'b1}}, {WF{1'b0}}} :
           {sgn, {(WE+WF){1'b0}}};
  end
endmodule

// File: rtl/output_ieee_stream.sv
// output_ieee_stream: 2-stage ready/valid FloPoCo-to-IEEE converter with saturating exception counters
module output_ieee_stream
  import flopoco_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOPOCO_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     nan_cnt,
  output logic [CNT_W-1:0]     inf_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  logic s1_valid, en1, en2, hs;
  logic [FLOPOCO_W-1:0] s1_word;
  logic [31:0] s1_ieee;
  cls_t s1_cls, s2_cls;
  flopoco_classify u_classify (.word(s1_word), .cls(s1_cls), .ieee(s1_ieee));
  assign en2 = !out_valid || out_ready;
  assign en1 = !s1_valid || en2;
  assign in_ready = en1;
  assign hs = out_valid && out_ready;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && !(&c)) ? c + 1'b1 : c;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      s2_cls <= CLS_ZERO;
      nan_cnt <= '0;
      inf_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (en1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_word <= in_data;
      end
      // out_data only moves when a real word arrives, so bubbles leave it untouched
      if (en2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_ieee;
          s2_cls <= s1_cls;
        end
      end
      nan_cnt <= clr_cnt ? '0 : bump(nan_cnt, hs && s2_cls == CLS_NAN);
      inf_cnt <= clr_cnt ? '0 : bump(inf_cnt, hs && (s2_cls == CLS_INF || s2_cls == CLS_OVF));
      flush_cnt <= clr_cnt ? '0 : bump(flush_cnt, hs && s2_cls == CLS_FLUSH);
    end
  end
endmodule

// File: tb/tb_output_ieee_stream.sv
// tb_output_ieee_stream: table, directed and randomized checks of the FloPoCo-to-IEEE stream
module tb_output_ieee_stream;
  localparam int CW = 4;
  localparam int SAT = 15;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [33:0] in_data;
  logic [31:0] out_data;
  logic [CW-1:0] nan_cnt, inf_cnt, flush_cnt;
  int passed = 0, total = 0;

  output_ieee_stream #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .clr_cnt(clr_cnt),
    .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // reference model: IEEE result straight from the conversion rules
  function automatic logic [31:0] ref_word(input logic [33:0] d);
    logic s;
    s = d[31];
    case (d[33:32])
      2'b00: return {s, 31'h0};
      2'b10: return {s, 8'hFF, 23'h0};
      2'b11: return 32'h7FC00000;
      default: begin
        if (d[30:23] == 8'd0) return {s, 31'h0};
        if (d[30:23] == 8'd255) return {s, 8'hFF, 23'h0};
        return d[31:0];
      end
    endcase
  endfunction

  // 0 = not counted, 1 = nan, 2 = inf/overflow, 3 = flush
  function automatic int ref_kind(input logic [33:0] d);
    if (d[33:32] == 2'b11) return 1;
    if (d[33:32] == 2'b10) return 2;
    if (d[33:32] == 2'b01 && d[30:23] == 8'd255) return 2;
    if (d[33:32] == 2'b01 && d[30:23] == 8'd0) return 3;
    return 0;
  endfunction

  function automatic int sat(input int x);
    return x < SAT ? x + 1 : SAT;
  endfunction

  function automatic logic [33:0] rand_word();
    logic [7:0] e;
    int r;
    r = $urandom_range(0, 7);
    e = r == 0 ? 8'd0 : r == 1 ? 8'd255 : 8'($urandom);
    return {2'($urandom_range(0, 3)), 1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic drive(input logic v, input logic [33:0] d, input logic r, input logic c);
    in_valid = v;
    in_data = d;
    out_ready = r;
    clr_cnt = c;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [33:0] din;
    logic [31:0] dout;
    int n, i, f;
  } vec_t;
  localparam int NV = 13;
  vec_t vec[NV];

  logic [31:0] q_word[$];
  int q_kind[$];
  int m_nan, m_inf, m_flush;
  logic prev_stall;
  logic [31:0] prev_data;

  task automatic rcycle(input logic v, input logic [33:0] d, input logic r, input logic c);
    int k;
    drive(v, d, r, c);
    chk("rnd_nan_cnt", nan_cnt, m_nan);
    chk("rnd_inf_cnt", inf_cnt, m_inf);
    chk("rnd_flush_cnt", flush_cnt, m_flush);
    if (prev_stall) begin
      chk("rnd_stall_valid", out_valid, 1);
      chk("rnd_stall_data", out_data, prev_data);
    end
    if (in_valid && in_ready) begin
      q_word.push_back(ref_word(in_data));
      q_kind.push_back(ref_kind(in_data));
    end
    k = 0;
    if (out_valid && out_ready) begin
      if (q_word.size() == 0) chk("rnd_spurious_out", 1, 0);
      else begin
        chk("rnd_out_data", out_data, q_word.pop_front());
        k = q_kind.pop_front();
      end
    end
    if (clr_cnt) begin
      m_nan = 0; m_inf = 0; m_flush = 0;
    end else begin
      if (k == 1) m_nan = sat(m_nan);
      if (k == 2) m_inf = sat(m_inf);
      if (k == 3) m_flush = sat(m_flush);
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] outs[$];
    logic [33:0] w[4];
    logic [31:0] we[4];
    int k;
    vec[0]  = '{34'h13F800000, 32'h3F800000, 0, 0, 0};
    vec[1]  = '{34'h280000000, 32'hFF800000, 0, 1, 0};
    vec[2]  = '{34'h300000000, 32'h7FC00000, 1, 1, 0};
    vec[3]  = '{34'h080000000, 32'h80000000, 1, 1, 0};
    vec[4]  = '{34'h100000005, 32'h00000000, 1, 1, 1};
    vec[5]  = '{34'h17F800001, 32'h7F800000, 1, 2, 1};
    vec[6]  = '{34'h1C0490FDB, 32'hC0490FDB, 1, 2, 1};
    vec[7]  = '{34'h000000000, 32'h00000000, 1, 2, 1};
    vec[8]  = '{34'h3FFFFFFFF, 32'h7FC00000, 2, 2, 1};
    vec[9]  = '{34'h212345678, 32'h7F800000, 2, 3, 1};
    vec[10] = '{34'h1807FFFFF, 32'h80000000, 2, 3, 2};
    vec[11] = '{34'h100800000, 32'h00800000, 2, 3, 2};
    vec[12] = '{34'h17F7FFFFF, 32'h7F7FFFFF, 2, 3, 2};

    do_reset();
    drive(0, '0, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_nan_cnt", nan_cnt, 0);
    chk("rst_inf_cnt", inf_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(negedge clk);

    for (int i = 0; i < NV + 3; i++) begin
      drive(i < NV, i < NV ? vec[i].din : 34'h0, 1, 0);
      if (i < NV) chk("tbl_in_ready", in_ready, 1);
      if (i >= 2 && i < NV + 2) begin
        chk("tbl_out_valid", out_valid, 1);
        chk("tbl_out_data", out_data, vec[i-2].dout);
      end else chk("tbl_bubble_valid", out_valid, 0);
      if (i >= 3) begin
        chk("tbl_nan_cnt", nan_cnt, vec[i-3].n);
        chk("tbl_inf_cnt", inf_cnt, vec[i-3].i);
        chk("tbl_flush_cnt", flush_cnt, vec[i-3].f);
      end
      @(negedge clk);
    end

    do_reset();
    w[0] = vec[0].din; w[1] = vec[1].din; w[2] = vec[2].din; w[3] = vec[6].din;
    we[0] = vec[0].dout; we[1] = vec[1].dout; we[2] = vec[2].dout; we[3] = vec[6].dout;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(k < 4, k < 4 ? w[k] : 34'h0, 0, 0);
      chk(c < 2 ? "stall_ready_hi" : "stall_ready_lo", in_ready, c < 2);
      if (c >= 2) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, we[0]);
      end
      if (in_valid && in_ready) k++;
      @(negedge clk);
    end
    chk("stall_accepts", k, 2);
    for (int c = 0; c < 20 && outs.size() < 4; c++) begin
      drive(k < 4, k < 4 ? w[k] : 34'h0, 1, 0);
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) outs.push_back(out_data);
      @(negedge clk);
    end
    chk("stall_out_count", outs.size(), 4);
    for (int i = 0; i < outs.size() && i < 4; i++) chk("stall_order", outs[i], we[i]);
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 1, 0);
      chk("stall_no_dup", out_valid, 0);
      @(negedge clk);
    end

    do_reset();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      drive(1, 34'h3DEADBEEF, 1, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0);
      @(negedge clk);
    end
    drive(0, '0, 1, 0);
    chk("sat_nan_cnt", nan_cnt, SAT);
    @(negedge clk);
    drive(1, 34'h300000000, 1, 0);
    @(negedge clk);
    drive(0, '0, 1, 0);
    @(negedge clk);
    drive(0, '0, 1, 1);
    chk("clr_handoff_valid", out_valid, 1);
    chk("clr_before_nan", nan_cnt, SAT);
    @(negedge clk);
    drive(0, '0, 1, 0);
    chk("clr_wins_nan", nan_cnt, 0);
    @(negedge clk);

    do_reset();
    drive(1, 34'h280000000, 1, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0);
      @(negedge clk);
    end
    drive(0, '0, 0, 0);
    chk("pre_rst_inf_cnt", inf_cnt, 1);
    @(negedge clk);
    drive(1, 34'h13F800000, 0, 0);
    @(negedge clk);
    drive(1, 34'h140000000, 0, 0);
    @(negedge clk);
    drive(0, '0, 0, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_inf_cnt", inf_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 34'h140000000, 1, 0);
    chk("post_rst_ready", in_ready, 1);
    @(negedge clk);
    drive(0, '0, 1, 0);
    chk("post_rst_lat1", out_valid, 0);
    @(negedge clk);
    drive(0, '0, 1, 0);
    chk("post_rst_lat2_valid", out_valid, 1);
    chk("post_rst_lat2_data", out_data, 32'h40000000);
    @(negedge clk);

    do_reset();
    m_nan = 0; m_inf = 0; m_flush = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 400; i++)
      rcycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    for (int i = 0; i < 6; i++) rcycle(0, '0, 1, 0);
    chk("rnd_drained", q_word.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/output_ieee_stream.md
# output_ieee_stream

Streaming converter from the 34-bit FloPoCo internal floating-point format to IEEE-754 single precision. It sits at the output end of the FloPoCo arithmetic datapath, after the adder/subtractor and the other FloPoCo operators, and hands standard 32-bit words to downstream memory and host logic. It is a 2-stage ready/valid pipeline with full throughput and backpressure. It also keeps saturating counters of exceptional results for debug.

## Interface
Parameters:
- CNT_W, 16, width of each exception counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a word.
- in_ready  out  1  the block accepts in_data this cycle.
- in_data  in  34  FloPoCo word: [33:32] exn, [31] sign, [30:23] exponent, [22:0] fraction.
- out_valid  out  1  out_data holds a converted word.
- out_ready  in  1  the consumer accepts out_data.
- out_data  out  32  IEEE-754 single-precision result.
- clr_cnt  in  1  synchronous clear of all counters.
- nan_cnt  out  CNT_W  number of NaN words delivered.
- inf_cnt  out  CNT_W  number of ±inf words delivered, including overflow.
- flush_cnt  out  CNT_W  number of normals flushed to zero.

## Operation
- Exception encoding: exn 00 = zero, 01 = normal, 10 = infinity, 11 = NaN.
- Conversion rules:
  - zero -> {sign, 8'h00, 23'h0}. Signed zero is preserved.
  - normal with exponent 1..254 -> {sign, exponent, fraction}, copied unchanged.
  - normal with exponent 0 -> {sign, 31'h0}. This is a flush and counts in flush_cnt.
  - normal with exponent 255 -> {sign, 8'hFF, 23'h0}. This is an overflow and counts in inf_cnt.
  - infinity -> {sign, 8'hFF, 23'h0}.
  - NaN -> 32'h7FC00000. Sign and payload are discarded.
- Stage 1 (S1) registers the word and decodes it into a class: ZERO, NORM, FLUSH, OVF, INF, NAN. Stage 2 (S2) registers the assembled IEEE word together with its class.
- Counters:
  - A counter updates only when a word is handed off (out_valid && out_ready), using the class of that word.
  - nan_cnt counts NAN. inf_cnt counts INF and OVF. flush_cnt counts FLUSH.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - If clr_cnt and a hand-off occur in the same cycle, clear wins and the counter becomes 0.
- in_data is ignored whenever in_valid is low.

## Timing
- Reset: out_valid=0, out_data=0, all counters=0, both pipeline valid bits=0. in_ready is high once rst is low.
- Stage enables:
  - en2 = !out_valid || out_ready.
  - en1 = !s1_valid || en2.
  - in_ready = en1. This is combinational from out_ready; there is no other combinational in-to-out path.
- Latency: a word accepted in cycle N appears on out_data in cycle N+2 when out_ready is held high.
- Throughput: one word per cycle while out_ready is high.
- Stall: while out_valid && !out_ready, out_data and out_valid hold stable. S1 still fills if it is empty.
  - With both stages full and out_ready low, in_ready=0.
  - Nothing is dropped or duplicated.
- A bubble (in_valid low) propagates as a cleared valid bit. It does not alter out_data while out_valid is 0.
- Reset asserted mid-stream flushes both stages immediately, asynchronously. Words in flight are lost and not counted.

## Structure
- Shared package flopoco_pkg holds:
  - the widths WE=8, WF=23, FLOPOCO_W=34;
  - the exn codes EXN_ZERO, EXN_NORM, EXN_INF, EXN_NAN;
  - the 3-bit class enum;
  - the constant IEEE_QNAN=32'h7FC00000.
- One combinational sub-module, flopoco_classify, maps a 34-bit word to {class, ieee_word}. S1 instantiates it. The pipeline registers, enables and counters live in the top level.

## Test plan
- Stream 34'h13F800000 (1.0) then 34'h280000000 (-inf) with out_ready=1 -> 32'h3F800000 at cycle +2, then 32'hFF800000 at cycle +3; inf_cnt=1.
- 34'h300000000, then 34'h080000000 -> 32'h7FC00000, then 32'h80000000; nan_cnt=1.
- Normal with exp 0 (34'h100000005), then with exp 255 (34'h17F800001) -> 32'h00000000 with flush_cnt=1, then 32'h7F800000 with inf_cnt=1.
- Hold out_ready=0 with a continuous input of 4 words -> in_ready drops after 2 accepts. Release out_ready: all 4 words emerge in order, none lost or duplicated, and out_data is stable during the stall.
- Push 2^CNT_W+3 NaNs with CNT_W=4 -> nan_cnt saturates at 15. Pulse clr_cnt together with a NaN hand-off -> nan_cnt=0.
- Assert rst with both stages full -> out_valid=0 and counters=0 immediately. The first word after reset emerges 2 cycles after it is accepted.
